// File: rtl/pocket_ctrl_pkg.sv
// Shared definitions for the front-panel mode sequencer: FSM state encoding
// and the positions of the meaningful keys inside the raw key vector.
package pocket_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_NEXT  = 1;
    localparam int KEY_PREV  = 2;
    localparam int KEY_EXIT  = 3;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: synchronises an active-low raw push-button,
// accepts a new level only after it has been stable for DB_CYCLES cycles,
// and emits a one-cycle pulse when the accepted level goes from released
// to pressed. Releasing the key never produces a pulse.
module key_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchroniser; idles at the released (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    // Accept the new level after DB_CYCLES consecutive disagreeing samples; pulse on press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DB_CYCLES - 1)) begin
                level      <= sync_b;
                stable_cnt <= '0;
                press      <= ~sync_b;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel mode controller: browses N_MODES sub-modules with wrap-around,
// launches the selected one through an active-low one-hot command and
// supervises its active-low feedback handshake, falling into FAULT when the
// module fails to acknowledge or release within ACK_TIMEOUT cycles.
module mode_sequencer
    import pocket_ctrl_pkg::*;
#(
    parameter int N_MODES     = 8,
    parameter int KEY_W       = 7,
    parameter int DB_CYCLES   = 250000,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           keys,
    input  logic [N_MODES-1:0]         feedback,
    output logic [N_MODES-1:0]         led,
    output logic [N_MODES-1:0]         command,
    output logic [$clog2(N_MODES)-1:0] sel,
    output logic                       fault
);

    localparam int SEL_W = $clog2(N_MODES);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    logic [KEY_W-1:0]   key_pulse;
    logic               unused_pulses;
    logic               do_exit;
    logic               do_enter;
    logic               do_next;
    logic               do_prev;

    state_t             state;
    state_t             state_d;
    logic [SEL_W-1:0]   sel_d;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_d;
    logic [N_MODES-1:0] command_d;
    logic [N_MODES-1:0] led_d;
    logic               fault_d;
    logic               timed_out;

    function automatic logic [N_MODES-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_MODES'(1) << idx;
    endfunction

    genvar k;
    generate
        for (k = 0; k < KEY_W; k++) begin : g_key
            key_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .key   (keys[k]),
                .press (key_pulse[k])
            );
        end
    endgenerate

    // Keys above EXIT carry no function; fold them into a sink.
    assign unused_pulses = ^key_pulse;

    // Resolve same-cycle presses so at most one key acts: EXIT > ENTER > NEXT > PREV.
    always_comb begin
        do_exit  = key_pulse[KEY_EXIT];
        do_enter = key_pulse[KEY_ENTER] & ~do_exit;
        do_next  = key_pulse[KEY_NEXT]  & ~do_exit & ~key_pulse[KEY_ENTER];
        do_prev  = key_pulse[KEY_PREV]  & ~do_exit & ~key_pulse[KEY_ENTER] & ~key_pulse[KEY_NEXT];
    end

    assign timed_out = (timer == TMR_W'(ACK_TIMEOUT));

    // Next-state, selection, timer and registered-output values.
    always_comb begin
        state_d   = state;
        sel_d     = sel;
        command_d = command;
        timer_d   = timed_out ? timer : timer + 1'b1;

        case (state)
            ST_IDLE: begin
                command_d = '1;
                if (feedback == '1) begin
                    if (do_enter) begin
                        command_d = ~onehot(sel);
                        state_d   = ST_ARM;
                    end else if (do_next) begin
                        sel_d = (sel == SEL_W'(N_MODES - 1)) ? '0 : sel + 1'b1;
                    end else if (do_prev) begin
                        sel_d = (sel == '0) ? SEL_W'(N_MODES - 1) : sel - 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (do_exit) begin
                    command_d = '1;
                    state_d   = ST_DRAIN;
                end else if (!feedback[sel]) begin
                    state_d = ST_RUN;
                end else if (timed_out) begin
                    command_d = '1;
                    state_d   = ST_FAULT;
                end
            end
            ST_RUN: begin
                if (do_exit) begin
                    command_d = '1;
                    state_d   = ST_DRAIN;
                end else if (feedback[sel]) begin
                    command_d = '1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                command_d = '1;
                if (feedback[sel]) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                command_d = '1;
                if (do_exit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                command_d = '1;
                state_d   = ST_IDLE;
            end
        endcase

        if (state_d != state) begin
            timer_d = '0;
        end

        led_d   = (state_d == ST_FAULT) ? '1 : onehot(sel_d);
        fault_d = (state_d == ST_FAULT);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sel     <= '0;
            timer   <= '0;
            command <= '1;
            led     <= N_MODES'(1);
            fault   <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            timer   <= timer_d;
            command <= command_d;
            led     <= led_d;
            fault   <= fault_d;
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer with short debounce and timeout
// settings; expected panel states are queued as stimulus is applied and
// compared once the DUT has had time to respond.
module tb_mode_sequencer;

    localparam int N_MODES     = 8;
    localparam int KEY_W       = 7;
    localparam int DB_CYCLES   = 4;
    localparam int ACK_TIMEOUT = 16;

    localparam logic [KEY_W-1:0] K_ENTER = 7'b0000001;
    localparam logic [KEY_W-1:0] K_NEXT  = 7'b0000010;
    localparam logic [KEY_W-1:0] K_PREV  = 7'b0000100;
    localparam logic [KEY_W-1:0] K_EXIT  = 7'b0001000;

    logic               clk;
    logic               rst;
    logic [KEY_W-1:0]   keys;
    logic [N_MODES-1:0] feedback;
    logic [N_MODES-1:0] led;
    logic [N_MODES-1:0] command;
    logic [2:0]         sel;
    logic               fault;

    int checks = 0;
    int errors = 0;
    int modelSel = 0;

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic [7:0] led;
        logic [7:0] command;
        logic       fault;
    } expect_t;

    expect_t sb[$];

    mode_sequencer #(
        .N_MODES     (N_MODES),
        .KEY_W       (KEY_W),
        .DB_CYCLES   (DB_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .feedback (feedback),
        .led      (led),
        .command  (command),
        .sel      (sel),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ledOf(input int s);
        return 8'(1) << s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int s, input logic [7:0] l,
                              input logic [7:0] c, input logic f);
        expect_t e;
        e.tag     = tag;
        e.sel     = 3'(s);
        e.led     = l;
        e.command = c;
        e.fault   = f;
        sb.push_back(e);
    endtask

    task automatic checkScoreboard();
        expect_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_sel"},     32'(sel),     32'(e.sel));
            checkOutput({e.tag, "_led"},     32'(led),     32'(e.led));
            checkOutput({e.tag, "_command"}, 32'(command), 32'(e.command));
            checkOutput({e.tag, "_fault"},   32'(fault),   32'(e.fault));
        end
    endtask

    task automatic applyStimulus(input logic [KEY_W-1:0] pressMask, input int holdCycles);
        keys = ~pressMask;
        repeat (holdCycles) @(negedge clk);
        keys = '1;
        repeat (12) @(negedge clk);
    endtask

    task automatic waitCommand(input logic [7:0] target, input int budget);
        int n = 0;
        while (command !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst      = 1'b0;
        keys     = '1;
        feedback = '1;
        repeat (3) @(negedge clk);
        pushExpect("reset", 0, 8'h01, 8'hFF, 1'b0);
        checkScoreboard();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] browse forward with wrap-around");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(K_NEXT, 12);
            modelSel = (modelSel == N_MODES - 1) ? 0 : modelSel + 1;
            pushExpect("next", modelSel, ledOf(modelSel), 8'hFF, 1'b0);
            checkScoreboard();
        end

        $display("[TB] browse backward with wrap-around");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(K_PREV, 12);
            modelSel = (modelSel == 0) ? N_MODES - 1 : modelSel - 1;
            pushExpect("prev", modelSel, ledOf(modelSel), 8'hFF, 1'b0);
            checkScoreboard();
        end

        $display("[TB] bouncing NEXT key");
        keys[1] = 1'b0;
        @(negedge clk);
        keys[1] = 1'b1;
        @(negedge clk);
        keys[1] = 1'b0;
        repeat (10) @(negedge clk);
        keys = '1;
        repeat (12) @(negedge clk);
        modelSel = 0;
        pushExpect("bounce", modelSel, ledOf(modelSel), 8'hFF, 1'b0);
        checkScoreboard();

        $display("[TB] long hold gives a single step");
        applyStimulus(K_NEXT, 40);
        applyStimulus(K_NEXT, 12);
        modelSel = 2;
        pushExpect("hold", modelSel, ledOf(modelSel), 8'hFF, 1'b0);
        checkScoreboard();

        $display("[TB] launch module 2 and complete handshake");
        keys = ~K_ENTER;
        waitCommand(8'hFB, 40);
        pushExpect("arm", 2, 8'h04, 8'hFB, 1'b0);
        checkScoreboard();
        repeat (5) @(negedge clk);
        feedback = 8'hFB;
        repeat (20) @(negedge clk);
        pushExpect("run", 2, 8'h04, 8'hFB, 1'b0);
        checkScoreboard();
        keys = '1;
        repeat (12) @(negedge clk);
        feedback = '1;
        repeat (3) @(negedge clk);
        pushExpect("done", 2, 8'h04, 8'hFF, 1'b0);
        checkScoreboard();

        $display("[TB] launch without acknowledge times out");
        keys = ~K_ENTER;
        waitCommand(8'hFB, 40);
        n = 0;
        while (!fault && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fault_latency", 32'(n), 32'(ACK_TIMEOUT + 1));
        keys = '1;
        repeat (12) @(negedge clk);
        pushExpect("fault", 2, 8'hFF, 8'hFF, 1'b1);
        checkScoreboard();
        applyStimulus(K_EXIT, 12);
        pushExpect("fault_exit", 2, 8'h04, 8'hFF, 1'b0);
        checkScoreboard();

        $display("[TB] ENTER and NEXT pressed together");
        keys = ~(K_ENTER | K_NEXT);
        waitCommand(8'hFB, 40);
        pushExpect("enter_next", 2, 8'h04, 8'hFB, 1'b0);
        checkScoreboard();
        feedback = 8'hFB;
        keys = ~K_EXIT;
        repeat (12) @(negedge clk);
        pushExpect("drain", 2, 8'h04, 8'hFF, 1'b0);
        checkScoreboard();
        feedback = '1;
        keys = '1;
        repeat (12) @(negedge clk);
        pushExpect("drain_done", 2, 8'h04, 8'hFF, 1'b0);
        checkScoreboard();

        $display("[TB] keys ignored while a foreign module is busy");
        feedback = 8'hEF;
        applyStimulus(K_NEXT, 12);
        applyStimulus(K_ENTER, 12);
        pushExpect("busy", 2, 8'h04, 8'hFF, 1'b0);
        checkScoreboard();
        feedback = '1;
        repeat (2) @(negedge clk);

        $display("[TB] asynchronous reset while running");
        keys = ~K_ENTER;
        waitCommand(8'hFB, 40);
        feedback = 8'hFB;
        repeat (3) @(negedge clk);
        pushExpect("pre_reset", 2, 8'h04, 8'hFB, 1'b0);
        checkScoreboard();
        keys = '1;
        #3;
        rst = 1'b0;
        #1;
        pushExpect("async_reset", 0, 8'h01, 8'hFF, 1'b0);
        checkScoreboard();
        @(negedge clk);
        feedback = '1;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
